// File: rtl/uart_pkg.sv
// Settings shared by the UART RX and TX datapaths. Both baud generators take
// their defaults and divisor arithmetic from here, so the two sides agree.
package uart_pkg;

    localparam int DEFAULT_CLK_HZ      = 25000000;
    localparam int DEFAULT_BAUD_RATE   = 9600;
    localparam int DEFAULT_SAMPLE_RATE = 16;

    // Clock cycles per oversampling tick, rounded down.
    function automatic int calc_divisor(input int clk_hz, input int baud_rate, input int sample_rate);
        return clk_hz / (baud_rate * sample_rate);
    endfunction

    // Two extra bits above what DIVISOR needs, so the compare value always fits.
    function automatic int count_width(input int divisor);
        return $clog2(divisor) + 2;
    endfunction

    // Offset loaded on an RX restart so that sampling lands mid-interval.
    function automatic int half_offset(input int divisor);
        return divisor / 2;
    endfunction

endpackage

// File: rtl/baud_rate_generator.sv
// Free-running oversampling tick generator. A receive restart loads a
// half-period offset and a transmit restart begins a full period.
module baud_rate_generator
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = DEFAULT_CLK_HZ,
    parameter int BAUD_RATE   = DEFAULT_BAUD_RATE,
    parameter int SAMPLE_RATE = DEFAULT_SAMPLE_RATE
) (
    input  logic clock,
    input  logic reset,
    input  logic start_rx,
    input  logic start_tx,
    output logic tick
);

    localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD_RATE, SAMPLE_RATE);
    localparam int COUNT_W = count_width(DIVISOR);

    localparam logic [COUNT_W-1:0] DIV_VAL  = COUNT_W'(DIVISOR);
    localparam logic [COUNT_W-1:0] HALF_VAL = COUNT_W'(half_offset(DIVISOR));

    generate
        if (DIVISOR < 2) begin : g_divisor_check
            $error("baud_rate_generator: DIVISOR must be at least 2");
        end
    endgenerate

    logic [COUNT_W-1:0] count;

    assign tick = (count == DIV_VAL);

    // A tick always clears the counter, so a start request that arrives on a tick is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (start_rx) begin
            count <= HALF_VAL;
        end else if (start_tx) begin
            count <= '0;
        end else begin
            count <= count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_baud_rate_generator.sv
// Self-checking bench for baud_rate_generator: default and small-divisor instances
// checked against tick-time arithmetic and an event-time reference model.
module tb_baud_rate_generator;

    localparam int D1 = 25000000 / (9600 * 16);
    localparam int D2 = 1600 / (10 * 16);

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start_rx = 1'b0;
    logic start_tx = 1'b0;
    logic start_rx2 = 1'b0;
    logic start_tx2 = 1'b0;
    logic tick;
    logic tick2;

    int tests_run = 0;
    int tests_failed = 0;

    baud_rate_generator dut (
        .clock    (clock),
        .reset    (reset),
        .start_rx (start_rx),
        .start_tx (start_tx),
        .tick     (tick)
    );

    baud_rate_generator #(
        .CLK_HZ      (1600),
        .BAUD_RATE   (10),
        .SAMPLE_RATE (16)
    ) dut2 (
        .clock    (clock),
        .reset    (reset),
        .start_rx (start_rx2),
        .start_tx (start_tx2),
        .tick     (tick2)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Edges until the chosen instance shows tick high; -1 if the limit expires.
    task automatic wait_tick(input bit second, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            cycle();
            if ((second ? tick2 : tick) === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int ticks_seen;
        bit exp;
        reset = 1'b0;
        start_rx = 1'b0;
        start_tx = 1'b0;
        cycle();
        tests_run++;
        if (tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_tick: got %b, expected 0", tick);
        end
        tests_run++;
        if (dut.count !== '0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d, expected 0", dut.count);
        end
        tests_run++;
        if (tick2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_tick2: got %b, expected 0", tick2);
        end
        reset = 1'b1;
        ticks_seen = 0;
        for (int k = 1; k <= 1000; k++) begin
            cycle();
            exp = (k >= D1) && ((k - D1) % (D1 + 1) == 0);
            if (tick === 1'b1) ticks_seen++;
            tests_run++;
            if (tick !== exp) begin
                tests_failed++;
                $display("FAIL free_run edge %0d: got %b, expected %b", k, tick, exp);
            end
        end
        tests_run++;
        if (ticks_seen != 6) begin
            tests_failed++;
            $display("FAIL free_run_count: got %0d ticks, expected 6", ticks_seen);
        end
    endtask

    task automatic pulse_and_measure(input bit rx, input bit tx, input int exp_first, input string name);
        int n;
        repeat ($urandom_range(1, 150)) cycle();
        if (tick === 1'b1) cycle();
        start_rx = rx;
        start_tx = tx;
        cycle();
        start_rx = 1'b0;
        start_tx = 1'b0;
        wait_tick(1'b0, 400, n);
        tests_run++;
        if (n != exp_first) begin
            tests_failed++;
            $display("FAIL %s_delay: got %0d edges, expected %0d", name, n, exp_first);
        end
        wait_tick(1'b0, 400, n);
        tests_run++;
        if (n != D1 + 1) begin
            tests_failed++;
            $display("FAIL %s_period: got %0d edges, expected %0d", name, n, D1 + 1);
        end
    endtask

    task automatic test_start_rx();
        for (int r = 0; r < 3; r++) pulse_and_measure(1'b1, 1'b0, D1 - D1 / 2, "start_rx");
    endtask

    task automatic test_start_tx();
        for (int r = 0; r < 3; r++) pulse_and_measure(1'b0, 1'b1, D1, "start_tx");
    endtask

    task automatic test_priority();
        int n;
        int held_ticks;
        pulse_and_measure(1'b1, 1'b1, D1 - D1 / 2, "rx_over_tx");
        wait_tick(1'b0, 400, n);
        start_rx = 1'b1;
        cycle();
        start_rx = 1'b0;
        tests_run++;
        if (dut.count !== '0) begin
            tests_failed++;
            $display("FAIL tick_over_rx_count: got %0d, expected 0", dut.count);
        end
        wait_tick(1'b0, 400, n);
        tests_run++;
        if (n != D1) begin
            tests_failed++;
            $display("FAIL tick_over_rx_delay: got %0d edges, expected %0d", n, D1);
        end
        // A held start_rx keeps reloading the half offset, so no tick appears.
        cycle();
        start_rx = 1'b1;
        held_ticks = 0;
        repeat (300) begin
            cycle();
            if (tick === 1'b1) held_ticks++;
        end
        start_rx = 1'b0;
        tests_run++;
        if (held_ticks != 0) begin
            tests_failed++;
            $display("FAIL held_rx_ticks: got %0d, expected 0", held_ticks);
        end
        wait_tick(1'b0, 400, n);
        tests_run++;
        if (n != D1 - D1 / 2) begin
            tests_failed++;
            $display("FAIL held_rx_release: got %0d edges, expected %0d", n, D1 - D1 / 2);
        end
    endtask

    task automatic test_async_reset();
        int n;
        wait_tick(1'b0, 400, n);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_tick_drop: got %b, expected 0", tick);
        end
        cycle();
        reset = 1'b1;
        wait_tick(1'b0, 400, n);
        tests_run++;
        if (n != D1) begin
            tests_failed++;
            $display("FAIL async_release1: got %0d edges, expected %0d", n, D1);
        end
        repeat ($urandom_range(2, 100)) cycle();
        #3;
        reset = 1'b0;
        #1;
        tests_run++;
        if (dut.count !== '0 || tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_mid_count: got count %0d tick %b, expected 0 0", dut.count, tick);
        end
        cycle();
        cycle();
        reset = 1'b1;
        wait_tick(1'b0, 400, n);
        tests_run++;
        if (n != D1) begin
            tests_failed++;
            $display("FAIL async_release2: got %0d edges, expected %0d", n, D1);
        end
    endtask

    task automatic test_param_sweep();
        int n;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        wait_tick(1'b1, 50, n);
        tests_run++;
        if (n != D2) begin
            tests_failed++;
            $display("FAIL sweep_first: got %0d edges, expected %0d", n, D2);
        end
        for (int r = 0; r < 2; r++) begin
            wait_tick(1'b1, 50, n);
            tests_run++;
            if (n != D2 + 1) begin
                tests_failed++;
                $display("FAIL sweep_period: got %0d edges, expected %0d", n, D2 + 1);
            end
        end
        repeat ($urandom_range(1, 8)) cycle();
        if (tick2 === 1'b1) cycle();
        start_rx2 = 1'b1;
        cycle();
        start_rx2 = 1'b0;
        wait_tick(1'b1, 50, n);
        tests_run++;
        if (n != 5) begin
            tests_failed++;
            $display("FAIL sweep_rx_delay: got %0d edges, expected 5", n);
        end
        repeat ($urandom_range(1, 8)) cycle();
        if (tick2 === 1'b1) cycle();
        start_tx2 = 1'b1;
        cycle();
        start_tx2 = 1'b0;
        wait_tick(1'b1, 50, n);
        tests_run++;
        if (n != D2) begin
            tests_failed++;
            $display("FAIL sweep_tx_delay: got %0d edges, expected %0d", n, D2);
        end
    endtask

    // Reference model: track the absolute edge index at which each tick is due.
    task automatic test_random();
        int nt1;
        int nt2;
        bit e1;
        bit e2;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        nt1 = D1;
        nt2 = D2;
        for (int k = 1; k <= 3000; k++) begin
            start_rx  = ($urandom_range(0, 63) == 0);
            start_tx  = ($urandom_range(0, 63) == 0);
            start_rx2 = ($urandom_range(0, 7) == 0);
            start_tx2 = ($urandom_range(0, 7) == 0);
            if (nt1 == k - 1)  nt1 = k + D1;
            else if (start_rx) nt1 = k + D1 - D1 / 2;
            else if (start_tx) nt1 = k + D1;
            if (nt2 == k - 1)   nt2 = k + D2;
            else if (start_rx2) nt2 = k + D2 - D2 / 2;
            else if (start_tx2) nt2 = k + D2;
            cycle();
            e1 = (nt1 == k);
            e2 = (nt2 == k);
            tests_run++;
            if (tick !== e1) begin
                tests_failed++;
                $display("FAIL random_tick edge %0d: got %b, expected %b", k, tick, e1);
            end
            tests_run++;
            if (tick2 !== e2) begin
                tests_failed++;
                $display("FAIL random_tick2 edge %0d: got %b, expected %b", k, tick2, e2);
            end
        end
        start_rx  = 1'b0;
        start_tx  = 1'b0;
        start_rx2 = 1'b0;
        start_tx2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_rx();
        test_start_tx();
        test_priority();
        test_async_reset();
        test_param_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
